// File: rtl/sdcmd_seq.sv
// sdcmd_seq: SD command-line sequencer.
// Frames and shifts out one 48-bit SD command per request. It then optionally
// collects a 48-bit reply, with a timeout, and checks the reply's framing and CRC7.
module sdcmd_seq #(
    parameter int LGTIMEOUT = 6
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_ckstb,
    input  logic        i_cfg_pp,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [5:0]  i_cmd_index,
    input  logic [31:0] i_cmd_arg,
    input  logic [1:0]  i_rsp_type,
    output logic        o_cmd_en,
    output logic        o_pp_cmd,
    output logic [1:0]  o_cmd_data,
    input  logic [1:0]  i_cmd_strb,
    input  logic [1:0]  i_cmd_data,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_err,
    output logic [37:0] o_rsp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_WAIT,
        S_RX,
        S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [47:0]            tx_sr;
    logic [5:0]             tx_cnt;
    logic [LGTIMEOUT-1:0]   to_cnt;
    logic [47:0]            rx_sr;
    logic [5:0]             rx_cnt;
    logic [1:0]             rsp_kind;
    logic [1:0]             err_q;
    logic [37:0]            rsp_q;

    logic [39:0]            cmd_word;
    logic [47:0]            cmd_frame;
    logic                   rsp_none;
    logic                   take_hi, take_lo;
    logic [47:0]            rx_nxt;
    logic [5:0]             rx_cnt_nxt;
    logic                   rx_start, rx_full, rx_frame_bad, rx_crc_bad;
    logic [1:0]             rx_err;
    logic                   wait_expired;

    // CRC7, polynomial x^7 + x^3 + 1, zero initial value, processed MSB first
    function automatic logic [6:0] crc7(input logic [39:0] bits);
        logic [6:0]  c;
        logic [39:0] b;
        logic        fb;
        c = '0;
        b = bits;
        for (int unsigned i = 0; i < 40; i++) begin
            fb = b[39] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
            b  = {b[38:0], 1'b0};
        end
        return c;
    endfunction

    assign cmd_word  = {2'b01, i_cmd_index, i_cmd_arg};
    assign cmd_frame = {cmd_word, crc7(cmd_word), 1'b1};
    assign rsp_none  = (rsp_kind == 2'b00) || (rsp_kind == 2'b11);
    assign o_rsp     = rsp_q;

    // Reply bit intake: hunt for the start bit in WAIT, shift up to 48 bits in RX ([1] before [0])
    always_comb begin
        take_hi    = 1'b0;
        take_lo    = 1'b0;
        rx_nxt     = rx_sr;
        rx_cnt_nxt = rx_cnt;
        if (state == S_RX) begin
            take_hi = i_cmd_strb[1];
            take_lo = i_cmd_strb[0];
        end else if (state == S_WAIT) begin
            // leading ones are idle line; once [1] is the start bit, [0] is already reply bit 2
            take_hi = i_cmd_strb[1] & ~i_cmd_data[1];
            take_lo = i_cmd_strb[0] & (take_hi | ~i_cmd_data[0]);
        end
        if (take_hi && rx_cnt_nxt != 6'd48) begin
            rx_nxt     = {rx_nxt[46:0], i_cmd_data[1]};
            rx_cnt_nxt = rx_cnt_nxt + 6'd1;
        end
        if (take_lo && rx_cnt_nxt != 6'd48) begin
            rx_nxt     = {rx_nxt[46:0], i_cmd_data[0]};
            rx_cnt_nxt = rx_cnt_nxt + 6'd1;
        end
    end

    assign rx_start     = (state == S_WAIT) && (take_hi || take_lo);
    assign rx_full      = (rx_cnt_nxt == 6'd48);
    assign rx_frame_bad = rx_nxt[46] | ~rx_nxt[0];
    assign rx_crc_bad   = (rsp_kind == 2'b01) && (crc7(rx_nxt[47:8]) != rx_nxt[7:1]);
    assign rx_err       = rx_frame_bad ? 2'b11 : (rx_crc_bad ? 2'b10 : 2'b00);
    assign wait_expired = i_ckstb && (to_cnt == '1);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // Next-state decode and PHY/handshake outputs
    always_comb begin
        state_nxt   = state;
        o_cmd_ready = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_err       = 2'b00;
        o_cmd_en    = 1'b0;
        o_pp_cmd    = 1'b0;
        o_cmd_data  = 2'b11;
        case (state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) state_nxt = S_TX;
            end
            S_TX: begin
                o_busy   = 1'b1;
                o_pp_cmd = i_cfg_pp;
                if (i_ckstb) begin
                    o_cmd_en   = 1'b1;
                    o_cmd_data = {2{tx_sr[47]}};
                    if (tx_cnt == 6'd47) state_nxt = rsp_none ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                o_busy = 1'b1;
                if (rx_start)          state_nxt = S_RX;
                else if (wait_expired) state_nxt = S_DONE;
            end
            S_RX: begin
                o_busy = 1'b1;
                if (rx_full) state_nxt = S_DONE;
            end
            S_DONE: begin
                o_done    = 1'b1;
                o_err     = err_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: command shifter, timeout counter, reply collector, result registers
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            tx_sr    <= '0;
            tx_cnt   <= '0;
            to_cnt   <= '0;
            rx_sr    <= '0;
            rx_cnt   <= '0;
            rsp_kind <= '0;
            err_q    <= '0;
            rsp_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        tx_sr    <= cmd_frame;
                        tx_cnt   <= '0;
                        rsp_kind <= i_rsp_type;
                        err_q    <= '0;
                    end
                end
                S_TX: begin
                    to_cnt <= '0;
                    rx_cnt <= '0;
                    if (i_ckstb) begin
                        tx_sr  <= {tx_sr[46:0], 1'b0};
                        tx_cnt <= tx_cnt + 6'd1;
                    end
                end
                S_WAIT: begin
                    rx_sr  <= rx_nxt;
                    rx_cnt <= rx_cnt_nxt;
                    if (i_ckstb) to_cnt <= to_cnt + LGTIMEOUT'(1);
                    if (!rx_start && wait_expired) err_q <= 2'b01;
                end
                S_RX: begin
                    rx_sr  <= rx_nxt;
                    rx_cnt <= rx_cnt_nxt;
                    if (rx_full) begin
                        err_q <= rx_err;
                        rsp_q <= rx_nxt[45:8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
